// File: rtl/wb_register_file_pkg.sv
// Shared CPU constants for the write-back stage and register file.
package wb_register_file_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

endpackage

// File: rtl/wb_result_mux.sv
// Write-back source select: ALU result or load data, zero latency.
module wb_result_mux #(
  parameter int XLEN = wb_register_file_pkg::XLEN
) (
  input  logic            MUX3_select,
  input  logic [XLEN-1:0] ALU_out,
  input  logic [XLEN-1:0] read_data,
  output logic [XLEN-1:0] wb_data
);
  import wb_register_file_pkg::*;

  always_comb begin
    wb_data = ALU_out;
    if (MUX3_select == WB_SRC_MEM) wb_data = read_data;
  end

endmodule

// File: rtl/wb_register_file.sv
// Write-back stage plus architectural register file with two bypassed read ports.
module wb_register_file #(
  parameter int XLEN      = wb_register_file_pkg::XLEN,
  parameter int NREG      = wb_register_file_pkg::NREG,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 MUX3_select,
  input  logic                                 regwrite_enable,
  input  logic [XLEN-1:0]                      ALU_out,
  input  logic [XLEN-1:0]                      read_data,
  input  logic [wb_register_file_pkg::REG_IDX_W-1:0] rd,
  input  logic [wb_register_file_pkg::REG_IDX_W-1:0] rs1_addr,
  input  logic [wb_register_file_pkg::REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]                      rs1_data,
  output logic [XLEN-1:0]                      rs2_data,
  output logic [XLEN-1:0]                      wb_data,
  output logic                                 wb_valid
);
  import wb_register_file_pkg::*;

  logic [XLEN-1:0] regs [NREG];

  wb_result_mux #(.XLEN(XLEN)) u_result_mux (
    .MUX3_select (MUX3_select),
    .ALU_out     (ALU_out),
    .read_data   (read_data),
    .wb_data     (wb_data)
  );

  // && short-circuits so an X on rd cannot leak into wb_valid when disabled
  assign wb_valid = regwrite_enable && (rd != '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (BYPASS_EN && wb_valid && (rs1_addr == rd))
      rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (BYPASS_EN && wb_valid && (rs2_addr == rd))
      rs2_data = wb_data;
  end

endmodule
